// File: rtl/hd_pkg.sv
// Shared hd parameter set: default word width and FIFO depth used across the hd data path,
// plus the operation encoding the reference FIFO uses to update its occupancy.
package hd_pkg;

  localparam int unsigned HD_K     = 4;
  localparam int unsigned HD_DEPTH = 16;

  // One FIFO cycle reduces to one of four effective operations.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e decode_op(input logic push, input logic pop);
    return fifo_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/hd_ref_ram.sv
// Storage array for the reference FIFO: one synchronous write port, one asynchronous read port.
module hd_ref_ram #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; occupancy, not contents, decides what is valid,
  // and leaving it unreset lets it map onto plain RAM/LUT storage.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hd_ref_fifo.sv
// First-word-fall-through reference FIFO between the data generator and the data checker,
// with sticky overflow, underflow and head-timeout flags.
module hd_ref_fifo
  import hd_pkg::*;
#(
  parameter int unsigned k       = HD_K,
  parameter int unsigned DEPTH   = HD_DEPTH,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [k-1:0]           gen_data,
  input  logic                   gen_vld,
  input  logic                   dec_vld,
  output logic [k-1:0]           din_d,
  output logic                   dvld_d,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf,
  output logic                   unf,
  output logic                   tout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("hd_ref_fifo: DEPTH must be a power of two and at least 4");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("hd_ref_fifo: TIMEOUT must be at least 1");
  end

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [TW-1:0] age;
  logic [TW-1:0] age_next;
  logic [k-1:0]  head_word;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  fifo_op_e      op;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A pop needs a valid head; a push into a full FIFO is only allowed when a pop frees the slot.
  assign pop  = dec_vld && !empty;
  assign push = gen_vld && (!full || pop);
  assign op   = decode_op(push, pop);

  // NOTE: every signal written here gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    age_next = '0;
    if (!empty && !pop) begin
      age_next = (age == TW'(TIMEOUT)) ? age : age + TW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      age    <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      tout   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      unique case (op)
        OP_PUSH: count <= count + CW'(1);
        OP_POP:  count <= count - CW'(1);
        default: count <= count;
      endcase

      age <= age_next;

      if (gen_vld && full && !pop) begin
        ovf <= 1'b1;
      end
      if (dec_vld && empty) begin
        unf <= 1'b1;
      end
      // age_next is only non-zero while a word stays at the head, so dvld_d is implied.
      if (age_next == TW'(TIMEOUT)) begin
        tout <= 1'b1;
      end
    end
  end

  hd_ref_ram #(
    .WIDTH (k),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push && !rst),
    .waddr (wr_ptr),
    .wdata (gen_data),
    .raddr (rd_ptr),
    .rdata (head_word)
  );

  assign dvld_d = !empty;
  assign din_d  = dvld_d ? head_word : '0;

endmodule

// File: tb/tb_hd_ref_fifo.sv
// Self-checking bench for hd_ref_fifo: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based model.
module tb_hd_ref_fifo;

  localparam int K       = 4;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [K-1:0] gen_data;
  logic         gen_vld;
  logic         dec_vld;
  logic [K-1:0] din_d;
  logic         dvld_d;
  logic [4:0]   count;
  logic         ovf;
  logic         unf;
  logic         tout;

  int n_checks = 0;
  int n_pass   = 0;

  hd_ref_fifo #(
    .k       (K),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .gen_data (gen_data),
    .gen_vld  (gen_vld),
    .dec_vld  (dec_vld),
    .din_d    (din_d),
    .dvld_d   (dvld_d),
    .count    (count),
    .ovf      (ovf),
    .unf      (unf),
    .tout     (tout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Behavioural model: a queue of stored words plus sticky flags and head age.
  logic [K-1:0] m_q[$];
  bit m_ovf, m_unf, m_tout;
  int m_age;
  bit started = 1'b0;

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_tout = 1'b0;
      m_age  = 0;
    end else begin
      automatic bit was_empty = (m_q.size() == 0);
      automatic bit was_full  = (m_q.size() == DEPTH);
      automatic bit do_pop    = dec_vld && !was_empty;
      if (dec_vld && was_empty) m_unf = 1'b1;
      if (gen_vld && was_full && !do_pop) m_ovf = 1'b1;
      if (do_pop) void'(m_q.pop_front());
      if (gen_vld && (!was_full || do_pop)) m_q.push_back(gen_data);
      if (was_empty || do_pop) m_age = 0;
      else if (m_age < TIMEOUT) m_age++;
      if (m_age == TIMEOUT) m_tout = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      automatic int n = m_q.size();
      check("count",  32'(count),  32'(n));
      check("dvld_d", 32'(dvld_d), 32'(n != 0));
      check("din_d",  32'(din_d),  (n != 0) ? 32'(m_q[0]) : 32'd0);
      check("ovf",    32'(ovf),    32'(m_ovf));
      check("unf",    32'(unf),    32'(m_unf));
      check("tout",   32'(tout),   32'(m_tout));
    end
  end

  task automatic cyc(input logic r, input logic gv, input logic [K-1:0] gd, input logic dv);
    rst      = r;
    gen_vld  = gv;
    gen_data = gd;
    dec_vld  = dv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b1, 4'hF, 1'b1);
  endtask

  initial begin
    logic [K-1:0] exp_words[$];
    rst = 1'b1; gen_vld = 1'b0; gen_data = '0; dec_vld = 1'b0;

    // Reset state
    do_reset();
    do_reset();
    check("rst_count", 32'(count), 0);
    check("rst_dvld",  32'(dvld_d), 0);
    check("rst_din",   32'(din_d), 0);
    check("rst_flags", 32'({ovf, unf, tout}), 0);

    // Three consecutive pushes
    cyc(0, 1, 4'h3, 0);
    cyc(0, 1, 4'h5, 0);
    cyc(0, 1, 4'hA, 0);
    check("p3_count", 32'(count), 3);
    check("p3_din",   32'(din_d), 32'h3);
    check("p3_dvld",  32'(dvld_d), 1);

    // Overfill by one, then drain in order
    do_reset();
    exp_words.delete();
    for (int i = 0; i < 17; i++) begin
      automatic logic [K-1:0] w = K'(i * 7 + 2);
      if (i < 16) exp_words.push_back(w);
      cyc(0, 1, w, 0);
    end
    check("ovf_count", 32'(count), 16);
    check("ovf_flag",  32'(ovf), 1);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      check("drain_word", 32'(din_d), 32'(exp_words[i]));
      cyc(0, 0, 0, 1);
    end
    check("drain_count", 32'(count), 0);
    check("drain_dvld",  32'(dvld_d), 0);

    // Pop while empty, then pop+push while empty
    do_reset();
    cyc(0, 0, 0, 1);
    check("unf_flag",  32'(unf), 1);
    check("unf_count", 32'(count), 0);
    check("unf_dvld",  32'(dvld_d), 0);
    do_reset();
    cyc(0, 1, 4'h7, 1);
    check("unf_push_count", 32'(count), 1);
    check("unf_push_din",   32'(din_d), 32'h7);
    check("unf_push_flag",  32'(unf), 1);

    // Full FIFO, simultaneous push and pop across the pointer wrap
    do_reset();
    exp_words.delete();
    for (int i = 0; i < 16; i++) begin
      exp_words.push_back(K'(i));
      cyc(0, 1, K'(i), 0);
    end
    for (int i = 0; i < 20; i++) begin
      check("wrap_head", 32'(din_d), 32'(exp_words.pop_front()));
      exp_words.push_back(K'(15 - (i % 16)));
      cyc(0, 1, K'(15 - (i % 16)), 1);
      check("wrap_count", 32'(count), 16);
    end
    check("wrap_ovf", 32'(ovf), 0);

    // Head timeout, then reset clears everything
    do_reset();
    cyc(0, 1, 4'h9, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) cyc(0, 0, 0, 0);
    check("tout_before", 32'(tout), 0);
    cyc(0, 0, 0, 0);
    check("tout_at", 32'(tout), 1);
    do_reset();
    check("clr_flags", 32'({ovf, unf, tout}), 0);
    check("clr_count", 32'(count), 0);
    check("clr_dvld",  32'(dvld_d), 0);

    // Randomized traffic in phases with different push/pop biases
    for (int ph = 0; ph < 24; ph++) begin
      automatic int push_pct = $urandom_range(0, 100);
      automatic int pop_pct  = (ph % 4 == 3) ? 0 : $urandom_range(0, 100);
      for (int i = 0; i < 100; i++) begin
        cyc(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 99) < push_pct),
            K'($urandom),
            ($urandom_range(0, 99) < pop_pct));
      end
    end

    cyc(0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
